dac_spi_driver: RTL

Serial DAC back-end for the function generator: it takes the 8-bit samples the generator produces on its DAC output and shifts each one, MSB first, into an external 8-bit SPI DAC. The DAC is MCP4801-style, with 16-bit frames and an LDAC latch strobe. It sits directly downstream of `generator` inside `wrapped_function_generator`. The sample port replaces the parallel `io_out[15:8]` drive, and the SPI pins go out on `io_out`. A 2-entry FIFO decouples generator sample timing from SPI frame timing.

---
 rtl/dac_spi_driver.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_driver.sv
// dac_spi_driver
// Serial back-end for the function generator. Samples are queued in a
// 2-entry FIFO and each one is sent MSB first to an MCP4801-style SPI DAC
// as a 16-bit frame {CMD_BITS, sample, 4'b0000}, followed by an LDAC strobe.
//
// Ports:
//   wb_clk_i        clock
//   wb_rst_n        asynchronous active-low reset
//   enable_i        allows FIFO pops and new frames
//   sample_i        8-bit sample from the generator
//   sample_valid_i  sample present on sample_i
//   sample_ready_o  FIFO can take a sample (combinational from enable_i)
//   dac_cs_n_o      SPI chip select, active-low
//   dac_sclk_o      SPI clock, mode 0
//   dac_mosi_o      SPI data
//   dac_ldac_n_o    DAC latch strobe, active-low
//   busy_o          frame engine not idle
//   underrun_o      sticky: frame finished while enabled with nothing queued
//   underrun_clr_i  clears underrun_o (a simultaneous set wins)
module dac_spi_driver #(
  parameter int         CLK_DIV  = 4,
  parameter logic [3:0] CMD_BITS = 4'b0011
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  input  logic       enable_i,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  output logic       sample_ready_o,
  output logic       dac_cs_n_o,
  output logic       dac_sclk_o,
  output logic       dac_mosi_o,
  output logic       dac_ldac_n_o,
  output logic       busy_o,
  output logic       underrun_o,
  input  logic       underrun_clr_i
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;

  // FIFO storage
  logic [7:0] fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_count;
  logic       ready_armed;
  logic       push;
  logic       pop;
  logic [7:0] fifo_head;

  // Frame engine registers
  state_t      state, state_n;
  logic [7:0]  div_cnt, div_n;
  logic [3:0]  bit_cnt, bit_n;
  logic        low_phase, low_phase_n;
  logic [14:0] shreg, shreg_n;
  logic        cs_n_q, cs_n_n;
  logic        sclk_q, sclk_n;
  logic        mosi_q, mosi_n;
  logic        ldac_n_q, ldac_n_n;
  logic        underrun_q, underrun_n;
  logic        div_last;

  // ready_armed keeps sample_ready_o low until the first clock after reset
  assign sample_ready_o = enable_i & ready_armed & (fifo_count != 2'd2);
  assign push           = sample_valid_i & sample_ready_o;
  assign fifo_head      = fifo_mem[rd_ptr];
  assign div_last       = (div_cnt == DIV_LAST);

  assign dac_cs_n_o   = cs_n_q;
  assign dac_sclk_o   = sclk_q;
  assign dac_mosi_o   = mosi_q;
  assign dac_ldac_n_o = ldac_n_q;
  assign busy_o       = (state != IDLE);
  assign underrun_o   = underrun_q;

  // FIFO data array; contents need no reset because count gates every read
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sample_i;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      ready_armed <= 1'b0;
    end else begin
      ready_armed <= 1'b1;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Next-state and next-output logic. The SPI pins are registered copies of
  // the *_n values, so every pin changes exactly on a state/phase boundary.
  // shreg holds the frame bits still to be sent after the one on MOSI.
  always_comb begin
    state_n     = state;
    div_n       = div_cnt + 8'd1;
    bit_n       = bit_cnt;
    low_phase_n = low_phase;
    shreg_n     = shreg;
    cs_n_n      = cs_n_q;
    sclk_n      = sclk_q;
    mosi_n      = mosi_q;
    ldac_n_n    = ldac_n_q;
    pop         = 1'b0;
    underrun_n  = underrun_q;
    if (underrun_clr_i) begin
      underrun_n = 1'b0;
    end

    case (state)
      IDLE: begin
        div_n = 8'd0;
        if (enable_i && (fifo_count != 2'd0)) begin
          pop     = 1'b1;
          shreg_n = {CMD_BITS[2:0], fifo_head, 4'b0000};
          mosi_n  = CMD_BITS[3];
          cs_n_n  = 1'b0;
          sclk_n  = 1'b0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_n       = 8'd0;
          bit_n       = 4'd0;
          low_phase_n = 1'b0;
          sclk_n      = 1'b1;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_n = 8'd0;
          if (!low_phase) begin
            // falling SCLK: present the next bit, except after the last one
            low_phase_n = 1'b1;
            sclk_n      = 1'b0;
            if (bit_cnt != 4'd15) begin
              mosi_n  = shreg[14];
              shreg_n = {shreg[13:0], 1'b0};
            end
          end else if (bit_cnt == 4'd15) begin
            cs_n_n  = 1'b1;
            mosi_n  = 1'b0;
            state_n = HOLD;
          end else begin
            bit_n       = bit_cnt + 4'd1;
            low_phase_n = 1'b0;
            sclk_n      = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          div_n    = 8'd0;
          ldac_n_n = 1'b0;
          state_n  = LDAC;
        end
      end
      LDAC: begin
        if (div_last) begin
          div_n    = 8'd0;
          ldac_n_n = 1'b1;
          state_n  = IDLE;
          if (enable_i && (fifo_count == 2'd0)) begin
            underrun_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset drives the pins idle immediately
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      low_phase  <= 1'b0;
      shreg      <= 15'd0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ldac_n_q   <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      low_phase  <= low_phase_n;
      shreg      <= shreg_n;
      cs_n_q     <= cs_n_n;
      sclk_q     <= sclk_n;
      mosi_q     <= mosi_n;
      ldac_n_q   <= ldac_n_n;
      underrun_q <= underrun_n;
    end
  end

endmodule
